// File: rtl/speck_round_engine.sv
// speck_round_engine
//   Iterative SPECK32/64 encryption core. It runs one round per clock and
//   expands the key schedule on the fly, so only the current round key k and
//   the three pending l words are stored.
//
// state | meaning
// IDLE  | waiting for a block; in_ready high
// RUN   | one round per cycle; round counter holds the index of the round in flight
// DONE  | ciphertext presented; waiting for out_ready
//
// Ports
//   clk       : clock, rising edge
//   rst_n     : asynchronous reset, active low
//   in_valid  : pt_x / pt_y / key are valid
//   in_ready  : engine is idle and will accept a block
//   pt_x/pt_y : plaintext upper/lower 16-bit words
//   key       : {l2, l1, l0, k0}
//   out_valid : ct_x / ct_y hold the ciphertext
//   out_ready : consumer accepts the ciphertext
//   ct_x/ct_y : ciphertext upper/lower 16-bit words
module speck_round_engine #(
  parameter int ROUNDS = 22,
  parameter int ALPHA  = 7,
  parameter int BETA   = 2
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [15:0] pt_x,
  input  logic [15:0] pt_y,
  input  logic [63:0] key,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [15:0] ct_x,
  output logic [15:0] ct_y
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam logic [4:0] LAST_ROUND = 5'(ROUNDS - 1);

  state_t      state;
  state_t      state_nxt;
  logic [15:0] x, y, k, l0, l1, l2;
  logic [4:0]  rnd;

  logic [15:0] x_nxt, y_nxt, k_nxt, l_new;

  function automatic logic [15:0] ror16(input logic [15:0] v);
    return (v >> ALPHA) | (v << (16 - ALPHA));
  endfunction

  function automatic logic [15:0] rol16(input logic [15:0] v);
    return (v << BETA) | (v >> (16 - BETA));
  endfunction

  // One round and one key-schedule step; both adds wrap modulo 2^16.
  always_comb begin
    x_nxt = (ror16(x) + y) ^ k;
    y_nxt = rol16(y) ^ x_nxt;
    l_new = (k + ror16(l0)) ^ {11'b0, rnd};
    k_nxt = rol16(k) ^ l_new;
  end

  // State register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic
  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (in_valid) state_nxt = RUN;
      RUN:  if (rnd == LAST_ROUND) state_nxt = DONE;
      DONE: if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Outputs; ct is forced to zero outside DONE so intermediate rounds never leak.
  always_comb begin
    in_ready  = (state == IDLE);
    out_valid = (state == DONE);
    ct_x      = 16'h0;
    ct_y      = 16'h0;
    if (state == DONE) begin
      ct_x = x;
      ct_y = y;
    end
  end

  // Datapath: the last RUN cycle also advances the key schedule, which is
  // harmless because the words are reloaded on the next accept.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      x   <= 16'h0;
      y   <= 16'h0;
      k   <= 16'h0;
      l0  <= 16'h0;
      l1  <= 16'h0;
      l2  <= 16'h0;
      rnd <= 5'd0;
    end else begin
      case (state)
        IDLE: begin
          if (in_valid) begin
            x   <= pt_x;
            y   <= pt_y;
            k   <= key[15:0];
            l0  <= key[31:16];
            l1  <= key[47:32];
            l2  <= key[63:48];
            rnd <= 5'd0;
          end
        end
        RUN: begin
          x   <= x_nxt;
          y   <= y_nxt;
          k   <= k_nxt;
          l0  <= l1;
          l1  <= l2;
          l2  <= l_new;
          rnd <= rnd + 5'd1;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_speck_round_engine.sv
module tb_speck_round_engine;

  localparam int ROUNDS = 22;
  localparam logic [31:0] KAT_CT = 32'ha868_42f2;
  localparam logic [15:0] KAT_X = 16'h6574;
  localparam logic [15:0] KAT_Y = 16'h694c;
  localparam logic [63:0] KAT_KEY = 64'h1918_1110_0908_0100;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        out_ready = 1'b0;
  logic [15:0] pt_x = 16'h0;
  logic [15:0] pt_y = 16'h0;
  logic [63:0] key = 64'h0;
  logic        in_ready;
  logic        out_valid;
  logic [15:0] ct_x;
  logic [15:0] ct_y;

  int errors = 0;
  int checks = 0;

  speck_round_engine #(.ROUNDS(ROUNDS), .ALPHA(7), .BETA(2)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready),
    .pt_x(pt_x), .pt_y(pt_y), .key(key),
    .out_valid(out_valid), .out_ready(out_ready),
    .ct_x(ct_x), .ct_y(ct_y)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] ror7(input logic [15:0] v);
    return (v >> 7) | (v << 9);
  endfunction

  function automatic logic [15:0] rol2(input logic [15:0] v);
    return (v << 2) | (v >> 14);
  endfunction

  // Reference SPECK32/64: full key expansion first, then all rounds.
  function automatic logic [31:0] enc(input logic [15:0] px, input logic [15:0] py,
                                     input logic [63:0] kk);
    logic [15:0] ks [0:31];
    logic [15:0] ls [0:34];
    logic [15:0] a, b;
    ks[0] = kk[15:0];
    ls[0] = kk[31:16];
    ls[1] = kk[47:32];
    ls[2] = kk[63:48];
    for (int i = 0; i < ROUNDS - 1; i++) begin
      ls[i+3] = (ks[i] + ror7(ls[i])) ^ 16'(i);
      ks[i+1] = rol2(ks[i]) ^ ls[i+3];
    end
    a = px;
    b = py;
    for (int i = 0; i < ROUNDS; i++) begin
      a = (ror7(a) + b) ^ ks[i];
      b = rol2(b) ^ a;
    end
    return {a, b};
  endfunction

  // Transaction-level timing model: 0 idle, 1 busy, 2 holding result.
  int          m_mode = 0;
  int          m_cnt = 0;
  logic [31:0] m_ct = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_mode = 0;
      m_cnt  = 0;
    end else begin
      case (m_mode)
        0: if (in_valid) begin
             m_ct   = enc(pt_x, pt_y, key);
             m_cnt  = ROUNDS;
             m_mode = 1;
           end
        1: begin
             m_cnt = m_cnt - 1;
             if (m_cnt == 0) m_mode = 2;
           end
        default: if (out_ready) m_mode = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    check("in_ready", {31'b0, in_ready}, {31'b0, m_mode == 0});
    check("out_valid", {31'b0, out_valid}, {31'b0, m_mode == 2});
    if (m_mode == 2) check("ct", {ct_x, ct_y}, m_ct);
  end

  // mode: 0 plain, 1 busy-input pulse mid-run, 2 scramble inputs every cycle
  task automatic run_block(input logic [15:0] px, input logic [15:0] py,
                           input logic [63:0] kk, input int bp, input int mode,
                           input logic lit);
    int c;
    logic [31:0] exp;
    logic [31:0] hold;
    exp = enc(px, py, kk);
    @(negedge clk);
    out_ready = (bp == 0);
    in_valid  = 1'b1;
    pt_x = px;
    pt_y = py;
    key  = kk;
    c = 0;
    while (!in_ready && c < 100) begin
      @(negedge clk);
      c++;
    end
    if (!in_ready) begin
      check("accept_timeout", 32'd0, 32'd1);
      in_valid = 1'b0;
      return;
    end
    c = 0;
    do begin
      @(negedge clk);
      c++;
      in_valid = 1'b0;
      if (mode == 1 && c == 5) begin
        in_valid = 1'b1;
        pt_x = 16'hffff;
        pt_y = 16'($urandom);
        key  = {$urandom, $urandom};
      end
      if (mode == 2) begin
        pt_x = 16'($urandom);
        pt_y = 16'($urandom);
        key  = {$urandom, $urandom};
      end
    end while (!out_valid && c < 100);
    check("latency", 32'(c), 32'(ROUNDS + 1));
    check("ct_vs_model", {ct_x, ct_y}, exp);
    if (lit) check("ct_kat", {ct_x, ct_y}, KAT_CT);
    if (bp > 0) begin
      hold = {ct_x, ct_y};
      repeat (bp) begin
        @(negedge clk);
        check("bp_valid", {31'b0, out_valid}, 32'd1);
        check("bp_ct", {ct_x, ct_y}, hold);
      end
      out_ready = 1'b1;
    end
    @(negedge clk);
    check("ready_after", {31'b0, in_ready}, 32'd1);
    check("valid_after", {31'b0, out_valid}, 32'd0);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int cyc, a1, a2, nout;

    check("model_kat", enc(KAT_X, KAT_Y, KAT_KEY), KAT_CT);

    repeat (3) @(negedge clk);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_ct", {ct_x, ct_y}, 32'd0);
    rst_n = 1'b1;

    // Known answer, then backpressure, busy input and unstable inputs
    run_block(KAT_X, KAT_Y, KAT_KEY, 0, 0, 1'b1);
    run_block(KAT_X, KAT_Y, KAT_KEY, 10, 0, 1'b1);
    run_block(KAT_X, KAT_Y, KAT_KEY, 0, 1, 1'b1);
    run_block(KAT_X, KAT_Y, KAT_KEY, 0, 2, 1'b1);

    // Back-to-back with in_valid held high
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pt_x = KAT_X;
    pt_y = KAT_Y;
    key  = KAT_KEY;
    cyc = 0; a1 = -1; a2 = -1; nout = 0;
    while (cyc < 200 && nout < 2) begin
      if (in_ready && in_valid) begin
        if (a1 < 0) a1 = cyc;
        else if (a2 < 0) a2 = cyc;
      end
      if (out_valid) begin
        nout++;
        check("b2b_ct", {ct_x, ct_y}, KAT_CT);
      end
      @(negedge clk);
      cyc++;
      if (a2 >= 0) in_valid = 1'b0;
    end
    in_valid = 1'b0;
    check("b2b_count", 32'(nout), 32'd2);
    check("b2b_spacing", 32'(a2 - a1), 32'd24);

    // Asynchronous reset in the middle of a run
    @(negedge clk);
    out_ready = 1'b1;
    in_valid  = 1'b1;
    pt_x = KAT_X;
    pt_y = KAT_Y;
    key  = KAT_KEY;
    cyc = 0;
    while (!in_ready && cyc < 100) begin
      @(negedge clk);
      cyc++;
    end
    repeat (10) begin
      @(negedge clk);
      in_valid = 1'b0;
    end
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("mid_rst_ct", {ct_x, ct_y}, 32'd0);
    check("mid_rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(negedge clk);
    @(negedge clk);
    rst_n = 1'b1;
    run_block(KAT_X, KAT_Y, KAT_KEY, 0, 0, 1'b1);

    // Random blocks with random backpressure
    for (int n = 0; n < 8; n++) begin
      run_block(16'($urandom), 16'($urandom), {$urandom, $urandom},
                int'($urandom_range(0, 3)), 0, 1'b0);
    end

    repeat (2) @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
